dpbram_ctrl: RTL and testbench

Parametrised true dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, an optional output register stage and a post-reset memory clear sequencer. It is the general-purpose successor to the single-port BRAM. It serves as shared instruction/data storage between the core and a second agent (UART loader or DMA) in the SoC. Both ports run on one clock; read data is accompanied by a valid strobe so consumers do not hard-code latency.

---
 rtl/dpbram_ctrl.sv | 156 +++++++++++++++
 tb/tb_dpbram_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpbram_ctrl.sv
// ============================================================================
// Module   : dpbram_ctrl
// Brief    : True dual-port byte-enabled block RAM with post-reset clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dpbram_ctrl #(
    parameter int DATA_BITWIDTH    = 32,
    parameter int ADDRESS_BITWIDTH = 10,
    parameter int OUTPUT_REG       = 0,
    parameter int RDW_MODE         = 0,
    parameter int CLEAR_ON_RESET   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          busy,
    input  logic                          a_enable,
    input  logic [DATA_BITWIDTH/8-1:0]    a_write_enable,
    input  logic [ADDRESS_BITWIDTH-1:0]   a_address,
    input  logic [DATA_BITWIDTH-1:0]      a_data_in,
    output logic [DATA_BITWIDTH-1:0]      a_data_out,
    output logic                          a_data_out_valid,
    input  logic                          b_enable,
    input  logic [DATA_BITWIDTH/8-1:0]    b_write_enable,
    input  logic [ADDRESS_BITWIDTH-1:0]   b_address,
    input  logic [DATA_BITWIDTH-1:0]      b_data_in,
    output logic [DATA_BITWIDTH-1:0]      b_data_out,
    output logic                          b_data_out_valid
);

    localparam int NB    = DATA_BITWIDTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_BITWIDTH;
    localparam logic [ADDRESS_BITWIDTH-1:0] C_ADDR_LAST = '1;
    localparam logic [ADDRESS_BITWIDTH-1:0] C_ADDR_ONE  = ADDRESS_BITWIDTH'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t C_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                        state_q;
    logic [ADDRESS_BITWIDTH-1:0]   clr_cnt_q;
    logic [DATA_BITWIDTH-1:0]      mem_q [DEPTH];

    logic                          a_req, b_req;
    logic                          a_wr, b_wr;
    logic [DATA_BITWIDTH-1:0]      a_rd_d, b_rd_d;
    logic [DATA_BITWIDTH-1:0]      a_dout_s1_q, b_dout_s1_q;
    logic                          a_vld_s1_q, b_vld_s1_q;

    function automatic logic [DATA_BITWIDTH-1:0] merge_bytes(
        input logic [DATA_BITWIDTH-1:0] old_w,
        input logic [NB-1:0]            we,
        input logic [DATA_BITWIDTH-1:0] din
    );
        logic [DATA_BITWIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) res[8*i +: 8] = din[8*i +: 8];
        end
        return res;
    endfunction

    // Clear sequencer: stops on the last word, never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= C_RST_STATE;
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == C_ADDR_LAST) begin
                state_q <= ST_READY;
            end else begin
                clr_cnt_q <= clr_cnt_q + C_ADDR_ONE;
            end
        end
    end

    assign busy  = (state_q == ST_CLEAR);
    assign a_req = a_enable && !busy && !rst;
    assign b_req = b_enable && !busy && !rst;
    assign a_wr  = a_req && (|a_write_enable);
    assign b_wr  = b_req && (|b_write_enable);

    // Cross-port reads always see the pre-write word; only the own-port merge applies.
    always_comb begin
        a_rd_d = mem_q[a_address];
        b_rd_d = mem_q[b_address];
        if (RDW_MODE != 0) begin
            a_rd_d = merge_bytes(mem_q[a_address], a_write_enable, a_data_in);
            b_rd_d = merge_bytes(mem_q[b_address], b_write_enable, b_data_in);
        end
    end

    // Port A lanes are written last so they win any same-lane collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_write_enable[i]) mem_q[b_address][8*i +: 8] <= b_data_in[8*i +: 8];
                if (a_wr && a_write_enable[i]) mem_q[a_address][8*i +: 8] <= a_data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dout_s1_q <= '0;
            b_dout_s1_q <= '0;
            a_vld_s1_q  <= 1'b0;
            b_vld_s1_q  <= 1'b0;
        end else begin
            a_vld_s1_q <= a_req;
            b_vld_s1_q <= b_req;
            if (a_req) a_dout_s1_q <= a_rd_d;
            if (b_req) b_dout_s1_q <= b_rd_d;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_BITWIDTH-1:0] a_dout_s2_q, b_dout_s2_q;
            logic                     a_vld_s2_q, b_vld_s2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_dout_s2_q <= '0;
                    b_dout_s2_q <= '0;
                    a_vld_s2_q  <= 1'b0;
                    b_vld_s2_q  <= 1'b0;
                end else begin
                    a_vld_s2_q <= a_vld_s1_q;
                    b_vld_s2_q <= b_vld_s1_q;
                    if (a_vld_s1_q) a_dout_s2_q <= a_dout_s1_q;
                    if (b_vld_s1_q) b_dout_s2_q <= b_dout_s1_q;
                end
            end

            assign a_data_out       = a_dout_s2_q;
            assign b_data_out       = b_dout_s2_q;
            assign a_data_out_valid = a_vld_s2_q;
            assign b_data_out_valid = b_vld_s2_q;
        end else begin : g_out_direct
            assign a_data_out       = a_dout_s1_q;
            assign b_data_out       = b_dout_s1_q;
            assign a_data_out_valid = a_vld_s1_q;
            assign b_data_out_valid = b_vld_s1_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dpbram_ctrl.sv
// ============================================================================
// Module   : tb_dpbram_ctrl
// Brief    : Directed self-checking bench for dpbram_ctrl (three configurations).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dpbram_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_en, b_en;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    // dut0: read-first, dut1: write-first, dut2: output register stage
    logic          busy0, busy1, busy2;
    logic [DW-1:0] a_do0, b_do0, a_do1, b_do1, a_do2, b_do2;
    logic          a_v0, b_v0, a_v1, b_v1, a_v2, b_v2;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    always #5 clk = ~clk;

    dpbram_ctrl #(.DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .OUTPUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr), .a_data_in(a_din),
        .a_data_out(a_do0), .a_data_out_valid(a_v0),
        .b_enable(b_en), .b_write_enable(b_we), .b_address(b_addr), .b_data_in(b_din),
        .b_data_out(b_do0), .b_data_out_valid(b_v0));

    dpbram_ctrl #(.DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .OUTPUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr), .a_data_in(a_din),
        .a_data_out(a_do1), .a_data_out_valid(a_v1),
        .b_enable(b_en), .b_write_enable(b_we), .b_address(b_addr), .b_data_in(b_din),
        .b_data_out(b_do1), .b_data_out_valid(b_v1));

    dpbram_ctrl #(.DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .OUTPUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst(rst), .busy(busy2),
        .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr), .a_data_in(a_din),
        .a_data_out(a_do2), .a_data_out_valid(a_v2),
        .b_enable(b_en), .b_write_enable(b_we), .b_address(b_addr), .b_data_in(b_din),
        .b_data_out(b_do2), .b_data_out_valid(b_v2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
        b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
    endtask

    // Inputs change at negedge; the following negedge shows the 1-cycle result.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_a(input logic [AW-1:0] ad, input logic [3:0] we, input logic [DW-1:0] d);
        a_en = 1'b1; a_we = we; a_addr = ad; a_din = d;
    endtask

    task automatic rd_b(input logic [AW-1:0] ad);
        b_en = 1'b1; b_we = '0; b_addr = ad; b_din = '0;
    endtask

    task automatic count_clear(input string tag);
        cnt = 0;
        while (busy0 && cnt < 100) begin
            cyc();
            cnt++;
        end
        check(tag, cnt, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        cyc();
        check("rst_busy", busy0, 1);
        check("rst_a_do", a_do0, 0);
        check("rst_b_v", b_v0, 0);
        check("rst_or_v", b_v2, 0);
        rst = 1'b0;
        count_clear("clr_len");
        check("busy_or", busy2, 0);

        // Whole array reads as zero after the clear.
        for (int i = 0; i < 16; i++) begin
            rd_b(AW'(i));
            cyc();
            check("clr_data", b_do0, 0);
            check("clr_valid", b_v0, 1);
            if (i > 0) check("clr_or_valid", b_v2, 1);
        end
        idle();
        cyc();
        check("strobe_drop", b_v0, 0);
        check("or_last_v", b_v2, 1);
        cyc();
        check("or_strobe_drop", b_v2, 0);

        // Byte-lane write.
        wr_a(3, 4'hF, 32'habcd_ef12);
        cyc();
        check("wr_valid", a_v0, 1);
        wr_a(3, 4'h1, 32'h0000_0055);
        cyc();
        check("rdw0_partial", a_do0, 32'habcd_ef12);
        check("rdw1_partial", a_do1, 32'habcd_ef55);
        idle();
        rd_b(3);
        cyc();
        check("byte_merge", b_do0, 32'habcd_ef55);
        idle();

        // Read-during-write, same and cross port.
        wr_a(5, 4'hF, 32'h1111_1111);
        cyc();
        wr_a(5, 4'hF, 32'h2222_2222);
        rd_b(5);
        cyc();
        check("rdw0_same", a_do0, 32'h1111_1111);
        check("rdw1_same", a_do1, 32'h2222_2222);
        check("rdw0_cross", b_do0, 32'h1111_1111);
        check("rdw1_cross", b_do1, 32'h1111_1111);
        idle();

        // Dual write collision.
        wr_a(7, 4'b0011, 32'hAAAA_AAAA);
        b_en = 1'b1; b_we = 4'b0110; b_addr = 7; b_din = 32'hBBBB_BBBB;
        cyc();
        idle();
        a_en = 1'b1; a_addr = 7;
        cyc();
        check("dual_wr", a_do0, 32'h00BB_AAAA);
        check("dual_wr_m1", a_do1, 32'h00BB_AAAA);
        idle();

        // Burst read, checking both latencies.
        for (int j = 0; j < 8; j++) begin
            wr_a(AW'(8 + j), 4'hF, 32'h1000_0000 + j);
            cyc();
        end
        idle();
        for (int j = 0; j < 8; j++) begin
            rd_b(AW'(8 + j));
            cyc();
            check("burst_or0", b_do0, 32'h1000_0000 + j);
            if (j == 0) begin
                check("or_latency", b_v2, 0);
            end else begin
                check("burst_or1_v", b_v2, 1);
                check("burst_or1", b_do2, 32'h1000_0000 + j - 1);
            end
        end
        idle();
        cyc();
        check("burst_or1_last", b_do2, 32'h1000_0007);
        check("burst_or1_lastv", b_v2, 1);
        cyc();
        check("burst_or1_end", b_v2, 0);
        check("burst_hold", b_do2, 32'h1000_0007);

        // Reset mid-read, then mid-clear.
        rd_b(3);
        cyc();
        check("pre_rst_v", b_v0, 1);
        rst = 1'b1;
        #1;
        check("async_v", b_v0, 0);
        check("async_do", b_do0, 0);
        idle();
        cyc();
        rst = 1'b0;
        repeat (6) cyc();
        check("mid_clear_busy", busy0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            if (cnt == 14) begin
                wr_a(2, 4'hF, 32'hDEAD_BEEF);
                rd_b(2);
            end else begin
                idle();
            end
            cyc();
            cnt++;
            if (cnt == 15) begin
                check("busy_no_av", a_v0, 0);
                check("busy_no_bv", b_v0, 0);
            end
        end
        idle();
        check("reclr_len", cnt, 16);
        rd_b(2);
        cyc();
        check("first_req_v", b_v0, 1);
        check("busy_no_wr", b_do0, 0);
        rd_b(3);
        cyc();
        check("reclr_addr3", b_do0, 0);
        rd_b(5);
        cyc();
        check("reclr_addr5", b_do1, 0);
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
